// File: rtl/fsm_pattern_gen.sv
// Stimulus transmitter for the 2-bit (q1,q2) sequence detector.
// Plays clean, aborted or odd re-entry symbol bursts per accepted command
// and tracks the detector's expected count alongside the driven symbols.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | waiting for a command, q=00, cmd_ready=1
//   GAP    | IDLE_GAP cycles of 00 ahead of each repetition
//   ODD    | first 01 symbol
//   ODD2   | second 01 symbol (odd re-entry mode only)
//   EVEN   | 10 symbol
//   FIN    | 11 symbol, held for cmd_hold+1 cycles
//   ABORT  | single 00 symbol ending an aborted repetition
module fsm_pattern_gen #(
  parameter int IDLE_GAP = 2,
  parameter int REP_W    = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [REP_W-1:0]  cmd_reps,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              q1,
  output logic              q2,
  output logic              busy,
  output logic              done,
  output logic [1:0]        exp_count
);

  // One counter serves both the gap length and the fin dwell.
  localparam int CNT_W = (HOLD_W > 4) ? HOLD_W : 4;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(IDLE_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_ODD   = 3'd2;
  localparam logic [2:0] S_ODD2  = 3'd3;
  localparam logic [2:0] S_EVEN  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [REP_W-1:0]  rep_cnt, rep_nxt;
  logic [1:0]        mode_r;
  logic [HOLD_W-1:0] hold_r;
  logic              accept, end_rep;
  logic [1:0]        q, prev_q, sym_nxt, exp_nxt;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && (state == S_IDLE);
  assign end_rep   = ((state == S_FIN) && (cnt == '0)) || (state == S_ABORT);
  assign q1        = q[1];
  assign q2        = q[0];

  // Next state, gap/dwell counter and repetition counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rep_nxt   = rep_cnt;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LOAD;
          rep_nxt   = (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
        end
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_ODD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ODD: begin
        case (mode_r)
          2'd1:    state_nxt = S_ABORT;
          2'd3:    state_nxt = S_ODD2;
          default: state_nxt = S_EVEN;
        endcase
      end
      S_ODD2: state_nxt = S_EVEN;
      S_EVEN: begin
        if (mode_r == 2'd2) begin
          state_nxt = S_ABORT;
        end else begin
          state_nxt = S_FIN;
          cnt_nxt   = CNT_W'(hold_r);
        end
      end
      S_FIN: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
      end
      S_ABORT: ;
      default: state_nxt = S_IDLE;
    endcase
    if (end_rep) begin
      rep_nxt = rep_cnt - REP_W'(1);
      if (rep_cnt == REP_W'(1)) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_GAP;
        cnt_nxt   = GAP_LOAD;
      end
    end
  end

  // Symbol for the state being entered, so q lines up with the state.
  always_comb begin
    case (state_nxt)
      S_ODD, S_ODD2: sym_nxt = 2'b01;
      S_EVEN:        sym_nxt = 2'b10;
      S_FIN:         sym_nxt = 2'b11;
      default:       sym_nxt = 2'b00;
    endcase
  end

  // Detector model: next count from the symbol currently on the wire.
  always_comb begin
    case (exp_count)
      2'b00:   exp_nxt = (q == 2'b01 && prev_q != 2'b01) ? 2'b01 : 2'b00;
      2'b01:   exp_nxt = (q == 2'b10) ? 2'b10 : (q == 2'b01) ? 2'b01 : 2'b00;
      default: exp_nxt = (q == 2'b11) ? 2'b11 : (q == 2'b01) ? 2'b01 : 2'b00;
    endcase
  end

  // Sequencer registers and command latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rep_cnt <= '0;
      mode_r  <= 2'd0;
      hold_r  <= '0;
      done    <= 1'b0;
      q       <= 2'b00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rep_cnt <= rep_nxt;
      done    <= (state != S_IDLE) && (state_nxt == S_IDLE);
      q       <= sym_nxt;
      if (accept) begin
        mode_r <= cmd_mode;
        hold_r <= cmd_hold;
      end
    end
  end

  // Expected detector count, lagging q by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_count <= 2'b00;
      prev_q    <= 2'b00;
    end else begin
      exp_count <= exp_nxt;
      prev_q    <= q;
    end
  end

endmodule

// File: tb/tb_fsm_pattern_gen.sv
// Bench for fsm_pattern_gen: a queue of expected per-cycle symbols built
// from each accepted command, checked every cycle, plus literal pins.
module tb_fsm_pattern_gen;

  localparam int IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] cmd_reps = 4'd0;
  logic [3:0] cmd_hold = 4'd0;
  logic       q1, q2, busy, done;
  logic [1:0] exp_count;

  fsm_pattern_gen #(.IDLE_GAP(IDLE_GAP), .REP_W(4), .HOLD_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_reps(cmd_reps), .cmd_hold(cmd_hold),
    .q1(q1), .q2(q2), .busy(busy), .done(done), .exp_count(exp_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] q;
    logic       busy;
    logic       done;
  } ent_t;

  ent_t       plan[$];
  logic [1:0] mq = 2'b00, mprev = 2'b00, mexp = 2'b00;
  logic       mbusy = 1'b0, mdone = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, req);
    end
  endtask

  function automatic logic [1:0] det(input logic [1:0] s, input logic [1:0] qq,
                                     input logic [1:0] p);
    case (s)
      2'b00:   return (qq == 2'b01 && p != 2'b01) ? 2'b01 : 2'b00;
      2'b01:   return (qq == 2'b10) ? 2'b10 : (qq == 2'b01) ? 2'b01 : 2'b00;
      default: return (qq == 2'b11) ? 2'b11 : (qq == 2'b01) ? 2'b01 : 2'b00;
    endcase
  endfunction

  task automatic push(input logic [1:0] s);
    plan.push_back('{q: s, busy: 1'b1, done: 1'b0});
  endtask

  // Whole symbol script for one command, followed by its done cycle.
  task automatic push_cmd(input int mode, input int reps, input int hold);
    int n;
    n = (reps == 0) ? 1 : reps;
    for (int r = 0; r < n; r++) begin
      for (int g = 0; g < IDLE_GAP; g++) push(2'b00);
      push(2'b01);
      if (mode == 3) push(2'b01);
      if (mode == 1) begin
        push(2'b00);
      end else if (mode == 2) begin
        push(2'b10);
        push(2'b00);
      end else begin
        push(2'b10);
        for (int h = 0; h <= hold; h++) push(2'b11);
      end
    end
    plan.push_back('{q: 2'b00, busy: 1'b0, done: 1'b1});
  endtask

  task automatic model_edge();
    ent_t e;
    if (!reset) begin
      plan.delete();
      mq = 2'b00; mprev = 2'b00; mexp = 2'b00; mbusy = 1'b0; mdone = 1'b0;
    end else begin
      mexp  = det(mexp, mq, mprev);
      mprev = mq;
      if (cmd_valid && !mbusy) push_cmd(int'(cmd_mode), int'(cmd_reps), int'(cmd_hold));
      if (plan.size() > 0) begin
        e = plan.pop_front();
        mq = e.q; mbusy = e.busy; mdone = e.done;
      end else begin
        mq = 2'b00; mbusy = 1'b0; mdone = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("q", int'({q1, q2}), int'(mq));
    check("busy", int'(busy), int'(mbusy));
    check("done", int'(done), int'(mdone));
    check("cmd_ready", int'(cmd_ready), int'(!mbusy));
    check("exp_count", int'(exp_count), int'(mexp));
  endtask

  // Accept one command from idle and watch n cycles.
  task automatic run_cmd(input int mode, input int reps, input int hold, input int n,
                         input int done_at, input int saw_fin);
    int first_done, n_done, fin;
    first_done = -1; n_done = 0; fin = 0;
    cmd_valid = 1'b1; cmd_mode = 2'(mode); cmd_reps = 4'(reps); cmd_hold = 4'(hold);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (exp_count == 2'b11) fin++;
    end
    check($sformatf("done_at_m%0d", mode), first_done, done_at);
    check($sformatf("done_cnt_m%0d", mode), n_done, 1);
    check($sformatf("fin_cycles_m%0d", mode), fin, saw_fin);
  endtask

  initial begin
    int lq[7];
    int le[7];
    int ld[7];
    int d1, d2;
    lq = '{0, 0, 1, 2, 3, 0, 0};
    le = '{0, 0, 0, 1, 2, 3, 0};
    ld = '{0, 0, 0, 0, 0, 1, 0};

    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_q", int'({q1, q2}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // Clean single rep, literal trace.
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_reps = 4'd1; cmd_hold = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
      check($sformatf("t1_q_T+%0d", k), int'({q1, q2}), lq[k-1]);
      check($sformatf("t1_exp_T+%0d", k), int'(exp_count), le[k-1]);
      check($sformatf("t1_done_T+%0d", k), int'(done), ld[k-1]);
    end
    repeat (2) step();

    // Multi rep with dwell, aborts, odd re-entry, reps=0.
    run_cmd(0, 3, 2, 25, 22, 9);
    run_cmd(1, 1, 0, 8, 5, 0);
    run_cmd(2, 1, 0, 8, 6, 0);
    run_cmd(3, 1, 0, 9, 7, 1);
    run_cmd(0, 0, 0, 8, 6, 1);

    // cmd_valid held high: second accept lands in the done cycle.
    d1 = -1; d2 = -1;
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_reps = 4'd1; cmd_hold = 4'd1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (done && d1 < 0) d1 = k;
      else if (done && d2 < 0) d2 = k;
      if (k == 8) check("hold_busy_T+8", int'(busy), 1);
    end
    cmd_valid = 1'b0;
    check("hold_done1", d1, 7);
    check("hold_done2", d2, 14);
    repeat (3) step();

    // Reset during FIN abandons the command, then immediate re-accept.
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_reps = 4'd1; cmd_hold = 4'd5;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) cmd_valid = 1'b0;
    end
    check("pre_rst_q", int'({q1, q2}), 3);
    reset = 1'b0;
    step();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_exp", int'(exp_count), 0);
    reset = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_reps = 4'd1;
    step();
    cmd_valid = 1'b0;
    check("post_rst_accept", int'(busy), 1);
    repeat (8) step();

    // Randomized traffic, occasional max reps and resets.
    for (int c = 0; c < 6000; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_reps  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      cmd_hold  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      reset     = ($urandom_range(0, 399) != 0);
      step();
    end
    reset = 1'b1; cmd_valid = 1'b0;
    repeat (400) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
